// File: rtl/counter_pkg.sv
// Shared types and default sizing for the counter subsystem.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

    localparam int COUNTER_WIDTH = 4;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: arms on start, decrements per enabled cycle, pulses done at terminal count.
// Latency: done rises N cycles after start is sampled with load N and enable held high.
// No backpressure: enable low pauses the count; abort cancels; start retriggers at any time.
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNTER_WIDTH,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count_val,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        // abort outranks start in both states, so a simultaneous start is dropped
        if (abort) begin
            count_d = '0;
            state_d = IDLE;
        end else if (start) begin
            if (load_val != '0) begin
                count_d  = load_val;
                reload_d = load_val;
                state_d  = RUN;
            end else begin
                count_d = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && enable) begin
            if (count_q == WIDTH'(1)) begin
                done_d = 1'b1;
                if (AUTO_RELOAD != 0) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    assign count_val = count_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign zero      = (count_q == '0);

endmodule
